niosii_system_sysid_checker: RTL

NIOSII_SYSTEM_SYSID_CHECKER -- requirements
Module: niosII_system_sysid_checker

---
 rtl/niosii_system_sysid_checker_pkg.sv | 21 ++
 rtl/niosii_system_sysid_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared definitions for the sysid checker: FSM state encoding, sysid word
// addresses and the default expected identification words.
package niosII_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    FIN     = 3'd5
  } state_e;

  localparam logic        SYSID_ADDR_ID = 1'b0;
  localparam logic        SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1490478491;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd1023;

endpackage

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid words 0 and 1 over Avalon-MM and compares them with the expected values.
// Defining SYSID_CHECKER_TIMEOUT_EN adds a per-phase timeout that aborts a stuck read.
module niosii_system_sysid_checker
  import niosII_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        seq_start;
  logic        in_access;
  logic        accept;
  logic        tmo_expired;
  logic        tmo_flag;

  assign seq_start   = (state_q == IDLE) && start;
  assign in_access   = (state_q == RD_ID) || (state_q == WAIT_ID) ||
                       (state_q == RD_TS) || (state_q == WAIT_TS);
  // Request lines decode straight from the state, so they stay frozen under waitrequest.
  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign accept      = avm_read && !avm_waitrequest;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    id_d    = id_q;
    ts_d    = ts_q;
    if (in_access && tmo_expired) begin
      state_d = FIN;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_start) begin
            state_d = RD_ID;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
        RD_ID: begin
          // Data may come back in the accept cycle itself; then the wait state is skipped.
          if (accept && avm_readdatavalid) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
          end else if (accept) begin
            state_d = WAIT_ID;
          end
        end
        WAIT_ID: begin
          if (avm_readdatavalid) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
          end
        end
        RD_TS: begin
          if (accept && avm_readdatavalid) begin
            ts_d    = avm_readdata;
            state_d = FIN;
          end else if (accept) begin
            state_d = WAIT_TS;
          end
        end
        WAIT_TS: begin
          if (avm_readdatavalid) begin
            ts_d    = avm_readdata;
            state_d = FIN;
          end
        end
        FIN: begin
          done_d  = 1'b1;
          pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS) && !tmo_flag;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit_q, tmo_hit_d;
  logic        timeout_q, timeout_d;
  logic        enter_rd;

  // The counter restarts at each read phase, so the limit applies per word, not per sequence.
  assign enter_rd    = (state_d != state_q) && ((state_d == RD_ID) || (state_d == RD_TS));
  assign tmo_expired = in_access && (tmo_cnt_q == TIMEOUT_CYCLES);
  assign tmo_flag    = tmo_hit_q;
  assign timeout     = timeout_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit_d = tmo_hit_q;
    timeout_d = timeout_q;
    if (enter_rd) begin
      tmo_cnt_d = '0;
    end else if (in_access) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
    if (seq_start) begin
      tmo_hit_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (tmo_expired) begin
      tmo_hit_d = 1'b1;
    end
    if (state_q == FIN) begin
      timeout_d = tmo_hit_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_hit_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_hit_q <= tmo_hit_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign tmo_flag    = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

endmodule
